// File: rtl/pcm_pdm_modulator.sv
// PCM-to-PDM transmit modulator: input FIFO of offset-binary samples feeding a
// first-order error-feedback sigma-delta that emits R bits per sample.
module pcm_pdm_modulator #(
  parameter int PDM_PCM_CONVERTER_DATA_WIDTH          = 16,
  parameter int PDM_PCM_CONVERTER_INTERPOLATION_RATIO = 16,
  parameter int PDM_PCM_CONVERTER_FIFO_DEPTH          = 4
) (
  input  logic                                           clock_i,
  input  logic                                           reset_n_i,
  input  logic signed [PDM_PCM_CONVERTER_DATA_WIDTH-1:0] pcm_data_i,
  input  logic                                           pcm_valid_i,
  output logic                                           pcm_ready_o,
  output logic                                           pdm_data_o,
  output logic                                           pdm_valid_o,
  input  logic                                           pdm_ready_i,
  input  logic                                           enable_i,
  output logic                                           busy_o,
  output logic                                           underflow_o
);

  localparam int W  = PDM_PCM_CONVERTER_DATA_WIDTH;
  localparam int R  = PDM_PCM_CONVERTER_INTERPOLATION_RATIO;
  localparam int D  = PDM_PCM_CONVERTER_FIFO_DEPTH;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(R);

  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  // Two's complement to offset binary: flipping the sign bit maps
  // -2^(W-1)..2^(W-1)-1 onto 0..2^W-1, which is the ones density target.
  function automatic logic [W-1:0] to_offset(input logic signed [W-1:0] s);
    return {~s[W-1], s[W-2:0]};
  endfunction

  logic [W-1:0]  fifo_mem [D];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [W-1:0]  acc;
  logic [W-1:0]  cur_u;
  logic          has_sample;
  logic [CW-1:0] bit_cnt;
  logic          underflow_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          first_load;
  logic          bit_hs;
  logic          boundary;
  logic [W:0]    sum;
  logic [W-1:0]  fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  assign pcm_ready_o = enable_i && !fifo_full;
  assign push        = pcm_valid_i && pcm_ready_o;

  assign pdm_valid_o = enable_i && has_sample;
  assign bit_hs      = pdm_valid_o && pdm_ready_i;
  assign boundary    = bit_hs && (bit_cnt == CNT_LAST);
  assign first_load  = enable_i && !has_sample && !fifo_empty;
  assign pop         = first_load || (boundary && !fifo_empty);

  // The carry out of acc + cur_u is the PDM bit; the low W bits are the
  // quantisation error fed back into the next bit.
  assign sum        = {1'b0, acc} + {1'b0, cur_u};
  assign pdm_data_o = sum[W];

  assign busy_o      = has_sample || !fifo_empty;
  assign underflow_o = underflow_q;

  // Sample storage carries data only; occupancy lives in the pointers.
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= to_offset(pcm_data_i);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc         <= '0;
      cur_u       <= '0;
      has_sample  <= 1'b0;
      bit_cnt     <= '0;
      underflow_q <= 1'b0;
    end else if (!enable_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc         <= '0;
      cur_u       <= '0;
      has_sample  <= 1'b0;
      bit_cnt     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      underflow_q <= boundary && fifo_empty;
      if (first_load) begin
        cur_u      <= fifo_head;
        has_sample <= 1'b1;
        bit_cnt    <= '0;
      end else if (bit_hs) begin
        acc     <= sum[W-1:0];
        bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_ONE;
        // On an empty FIFO cur_u is simply kept, repeating the last sample.
        if (boundary && !fifo_empty) begin
          cur_u <= fifo_head;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_pdm_modulator.sv
// Directed bench for pcm_pdm_modulator (W=16, R=4, depth 4) with hand-computed
// PDM bit patterns.
module tb_pcm_pdm_modulator;

  localparam int W = 16;
  localparam int R = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] pcm_data = '0;
  logic         pcm_valid = 1'b0;
  logic         pdm_ready = 1'b0;
  logic         enable = 1'b0;
  logic         pcm_ready_o;
  logic         pdm_data_o;
  logic         pdm_valid_o;
  logic         busy_o;
  logic         underflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcm_pdm_modulator #(
    .PDM_PCM_CONVERTER_DATA_WIDTH(W),
    .PDM_PCM_CONVERTER_INTERPOLATION_RATIO(R),
    .PDM_PCM_CONVERTER_FIFO_DEPTH(D)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .pcm_data_i(pcm_data),
    .pcm_valid_i(pcm_valid),
    .pcm_ready_o(pcm_ready_o),
    .pdm_data_o(pdm_data_o),
    .pdm_valid_o(pdm_valid_o),
    .pdm_ready_i(pdm_ready),
    .enable_i(enable),
    .busy_o(busy_o),
    .underflow_o(underflow_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one sample at a falling edge; it is taken on the next rising edge.
  task automatic push(input logic [W-1:0] d, input logic exp_ready, input string tag);
    pcm_data  = d;
    pcm_valid = 1'b1;
    #1 check_eq(tag, pcm_ready_o, exp_ready);
    @(negedge clk);
    pcm_valid = 1'b0;
  endtask

  task automatic get_bit(input string tag, output logic b);
    int n = 0;
    while (!(pdm_valid_o && pdm_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, pdm_valid_o, 1'b1);
    b = pdm_data_o;
    @(negedge clk);
  endtask

  task automatic run_bits(input string tag, input logic [31:0] pat, input int n,
                          input logic uf_end);
    logic b;
    for (int i = 0; i < n; i++) begin
      if (i > 0) check_eq($sformatf("%s_uf%0d", tag, i), underflow_o, 1'b0);
      get_bit($sformatf("%s_v%0d", tag, i), b);
      check_eq($sformatf("%s_b%0d", tag, i), b, pat[n-1-i]);
    end
    check_eq({tag, "_uf_end"}, underflow_o, uf_end);
  endtask

  task automatic flush();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset and enable
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_pcm_ready", pcm_ready_o, 1'b0);
    check_eq("rst_pdm_valid", pdm_valid_o, 1'b0);
    check_eq("rst_pdm_data", pdm_data_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_underflow", underflow_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("dis_pcm_ready", pcm_ready_o, 1'b0);
    enable = 1'b1;
    #1;
    check_eq("en_pcm_ready", pcm_ready_o, 1'b1);
    check_eq("en_pdm_valid", pdm_valid_o, 1'b0);
    check_eq("en_busy", busy_o, 1'b0);
    @(negedge clk);

    // Mid-scale sample: 0,1,0,1 then underflow and repeat
    pdm_ready = 1'b1;
    push(16'h0000, 1'b1, "t2_ready");
    check_eq("t2_lat_valid0", pdm_valid_o, 1'b0);
    check_eq("t2_busy", busy_o, 1'b1);
    @(negedge clk);
    check_eq("t2_lat_valid1", pdm_valid_o, 1'b1);
    run_bits("t2a", 32'b0101, 4, 1'b1);
    run_bits("t2b", 32'b0101, 4, 1'b1);
    flush();

    // Full-scale negative then positive, refilled in time
    push(16'h8000, 1'b1, "t3_push0");
    push(16'h7FFF, 1'b1, "t3_push1");
    run_bits("t3", 32'b0000_0111, 8, 1'b1);
    flush();

    // Stall in the middle of a sample
    push(16'h0000, 1'b1, "t4_push");
    run_bits("t4a", 32'b01, 2, 1'b0);
    pdm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_stall_data%0d", i), pdm_data_o, 1'b0);
      check_eq($sformatf("t4_stall_valid%0d", i), pdm_valid_o, 1'b1);
      check_eq($sformatf("t4_stall_uf%0d", i), underflow_o, 1'b0);
      @(negedge clk);
    end
    pdm_ready = 1'b1;
    run_bits("t4b", 32'b01, 2, 1'b1);
    flush();

    // Fill: one loaded plus four queued, sixth refused, drained in order
    pdm_ready = 1'b0;
    push(16'h8000, 1'b1, "t5_push0");
    push(16'h7FFF, 1'b1, "t5_push1");
    push(16'h4000, 1'b1, "t5_push2");
    push(16'h0000, 1'b1, "t5_push3");
    push(16'hC000, 1'b1, "t5_push4");
    push(16'h1111, 1'b0, "t5_push5_full");
    check_eq("t5_ready_after", pcm_ready_o, 1'b0);
    check_eq("t5_busy", busy_o, 1'b1);
    check_eq("t5_first_data", pdm_data_o, 1'b0);
    pdm_ready = 1'b1;
    run_bits("t5", 32'b0000_0111_1110_1010_1000, 20, 1'b1);
    flush();

    // Enable drop while busy discards queue, accumulator and the push offered
    pdm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h7FFF, 1'b1, $sformatf("t6_push%0d", i));
    pdm_ready = 1'b1;
    @(negedge clk);
    pdm_ready = 1'b0;
    check_eq("t6_busy_before", busy_o, 1'b1);
    enable    = 1'b0;
    pcm_valid = 1'b1;
    pcm_data  = 16'h1234;
    #1;
    check_eq("t6_dis_pcm_ready", pcm_ready_o, 1'b0);
    check_eq("t6_dis_pdm_valid", pdm_valid_o, 1'b0);
    @(negedge clk);
    enable    = 1'b1;
    pcm_valid = 1'b0;
    #1;
    check_eq("t6_busy_after", busy_o, 1'b0);
    check_eq("t6_valid_after", pdm_valid_o, 1'b0);
    check_eq("t6_ready_after", pcm_ready_o, 1'b1);
    check_eq("t6_uf_after", underflow_o, 1'b0);
    @(negedge clk);
    check_eq("t6_idle_valid", pdm_valid_o, 1'b0);
    check_eq("t6_idle_busy", busy_o, 1'b0);
    check_eq("t6_idle_uf", underflow_o, 1'b0);
    pdm_ready = 1'b1;
    push(16'h0000, 1'b1, "t6_push_new");
    run_bits("t6", 32'b0101, 4, 1'b1);
    flush();

    // Asynchronous reset mid-sample
    push(16'h7FFF, 1'b1, "t7_push");
    run_bits("t7a", 32'b01, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_valid", pdm_valid_o, 1'b0);
    check_eq("t7_rst_busy", busy_o, 1'b0);
    check_eq("t7_rst_data", pdm_data_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(16'h0000, 1'b1, "t7_push_new");
    run_bits("t7b", 32'b0101, 4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
